host_slowdown_rx: RTL and testbench
===================================

// Module: host_slowdown_rx
// PURPOSE
//  Receive-side parser for host-to-target control frames on the RVVI Ethernet link.
//  - Consumes the decoded, clk-synchronous RX byte stream.
//  - Recognises slow-down request frames (matching MAC + EtherType + opcode).
//  - Produces the HostRequestSlowDown pulse and the latched HostFiFoFillAmt word.
//  - Both outputs feed the slow-down frame generator directly downstream.
// PARAMETERS
//  LOCAL_MAC     48'h02_00_00_00_00_01  destination MAC accepted (broadcast FF..FF also accepted)
//  ETHER_TYPE    16'h88B5               EtherType of control frames
//  OP_SLOWDOWN   8'h01                  opcode byte identifying a slow-down request
//  HOLD_CYCLES   4                      cycles HostRequestSlowDown stays high per request; legal 2..8
// PORTS
//  clk                  in   1   clock
//  reset                in   1   synchronous, active-high reset
//  RxValid              in   1   RxData/RxLast/RxError qualify this cycle
//  RxData               in   8   frame byte, MAC dest first, FCS already stripped
//  RxLast               in   1   final byte of frame (valid only with RxValid)
//  RxError              in   1   PHY/FCS error flagged on this beat (valid only with RxValid)
//  HostRequestSlowDown  out  1   level pulse, HOLD_CYCLES long, per accepted request
//  HostFiFoFillAmt      out  32  fill amount from last accepted request (big-endian in frame)
//  FrameMatchCount      out  16  accepted requests, saturating
//  FrameDropCount       out  16  frames aborted after a MAC+type match, saturating
// BEHAVIOUR
//  Reset: all outputs 0; FSM to IDLE; hold counter 0.
//  FSM, advances only on RxValid beats (no RxValid = hold state):
//   IDLE->DST on first beat.
//   DST (6 B): compare against LOCAL_MAC / broadcast; mismatch -> mark miss.
//   SRC (6 B): ignored.
//   TYPE (2 B): compare against ETHER_TYPE.
//   OPCODE (1 B): compare against OP_SLOWDOWN.
//   FILL (4 B): shift MSB-first into a staging register.
//   DRAIN: consume the remaining bytes until RxLast.
//  Byte index counter: 3 bits, cleared on every state change.
//  Any miss (MAC, type or opcode) -> DRAIN; frame ignored silently, no counters change.
//  RxLast -> IDLE next cycle from any state.
//  Commit: accepted only if RxLast arrives, with RxError=0 on every beat, on the 4th FILL byte or in DRAIN.
//   - Cycle after that beat: HostFiFoFillAmt <= staging value.
//   - Same cycle: HostRequestSlowDown rises; FrameMatchCount +1.
//   - Latency: RxLast beat -> HostRequestSlowDown high = 1 cycle.
//  Drop, for frames that passed MAC+type only:
//   - RxError on any beat, or RxLast before FILL completes.
//   - Frame is discarded: HostFiFoFillAmt unchanged, FrameDropCount +1 at frame end.
//   - After RxError, remaining beats go to DRAIN until RxLast.
//  Pulse: high exactly HOLD_CYCLES cycles, then low.
//   - Minimum accepted frame is 19 B, so back-to-back commits always see >=11 low cycles.
//   - Downstream edge detect therefore sees one edge per request.
//   - HOLD_CYCLES >8 is a compile-time error.
//  Counters saturate at 16'hFFFF, no wrap.
//  reset mid-frame: immediate abandon; no count change; next beat is treated as frame start.
// STRUCTURE
//  Package cvw: rx FSM state typedef, RVVI_CTRL_ETHERTYPE, RVVI_OP_SLOWDOWN constants.
//  Sub-module pulse_stretch #(HOLD_CYCLES): commit strobe in -> fixed-width level pulse out.
//  Reuse the shared flopenr / counter cells for staging, fill and stat registers.
// TESTING
//  1. Valid frame: MAC 02..01, type 88B5, op 01, fill 00_00_12_34, 40 pad B
//     -> fill=32'h1234 and req high 4 cycles, starting 1 cycle after RxLast; match=1.
//  2. Same frame with dest MAC 02..02
//     -> no pulse; fill unchanged; both counts unchanged.
//  3. RxError on 2nd fill byte
//     -> no pulse; fill holds prior value; drop=1.
//  4. RxLast on 4th fill byte, no padding
//     -> commit accepted; pulse generated.
//  5. Two valid frames back-to-back with RxValid gaps inserted
//     -> two distinct pulses with >=1 low cycle between; match=2; fill = second value.
//  6. reset asserted at byte 10 of a frame, next frame valid
//     -> outputs 0 during reset; next frame commits normally.

Source files
------------

// File: rtl/host_slowdown_rx_pkg.sv
// host_slowdown_rx_pkg: shared types and constants for the RVVI host slow-down receive path
package host_slowdown_rx_pkg;

    typedef enum logic [2:0] {
        RX_IDLE,
        RX_DST,
        RX_SRC,
        RX_TYPE,
        RX_OPCODE,
        RX_FILL,
        RX_DRAIN
    } rxState_t;

    localparam logic [47:0] RVVI_LOCAL_MAC      = 48'h02_00_00_00_00_01;
    localparam logic [15:0] RVVI_CTRL_ETHERTYPE = 16'h88B5;
    localparam logic [7:0]  RVVI_OP_SLOWDOWN    = 8'h01;
    localparam int          RVVI_SLOWDOWN_HOLD  = 4;

    // Byte k of a MAC address in wire order (k=0 is the first byte on the wire)
    function automatic logic [7:0] macByte(input logic [47:0] mac, input logic [2:0] k);
        return mac[8 * (5 - int'(k)) +: 8];
    endfunction

endpackage

// File: rtl/host_slowdown_rx_pulse_stretch.sv
// pulse_stretch: turns a one-cycle commit strobe into a HOLD_CYCLES-wide level pulse
module pulse_stretch #(
    parameter int HOLD_CYCLES = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic strobe,
    output logic pulse
);

    if (HOLD_CYCLES < 2 || HOLD_CYCLES > 8) begin : g_badHold
        $error("pulse_stretch: HOLD_CYCLES must be in 2..8");
    end

    logic [3:0] holdCnt;

    // Reload on every strobe, otherwise count down to zero
    always_ff @(posedge clk) begin
        if (reset)
            holdCnt <= 4'd0;
        else if (strobe)
            holdCnt <= 4'(HOLD_CYCLES);
        else if (holdCnt != 4'd0)
            holdCnt <= holdCnt - 4'd1;
    end

    assign pulse = holdCnt != 4'd0;

endmodule

// File: rtl/host_slowdown_rx.sv
// host_slowdown_rx: parses host control frames and raises slow-down requests with the requested fill amount
module host_slowdown_rx
    import host_slowdown_rx_pkg::*;
#(
    parameter logic [47:0] LOCAL_MAC   = RVVI_LOCAL_MAC,
    parameter logic [15:0] ETHER_TYPE  = RVVI_CTRL_ETHERTYPE,
    parameter logic [7:0]  OP_SLOWDOWN = RVVI_OP_SLOWDOWN,
    parameter int          HOLD_CYCLES = RVVI_SLOWDOWN_HOLD
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        RxValid,
    input  logic [7:0]  RxData,
    input  logic        RxLast,
    input  logic        RxError,
    output logic        HostRequestSlowDown,
    output logic [31:0] HostFiFoFillAmt,
    output logic [15:0] FrameMatchCount,
    output logic [15:0] FrameDropCount
);

    rxState_t    state, stateNext;
    logic [2:0]  idx, idxNext;
    logic        localOk, localOkNext;
    logic        bcastOk, bcastOkNext;
    logic        typeOk, typeOkNext;
    logic        armed, armedNext;
    logic        errSeen, errNext;
    logic [31:0] staging, stageNext;
    logic        commit, drop;

    // Frame state and per-frame flags; reset abandons any frame in flight
    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= RX_IDLE;
            idx     <= 3'd0;
            localOk <= 1'b0;
            bcastOk <= 1'b0;
            typeOk  <= 1'b0;
            armed   <= 1'b0;
            errSeen <= 1'b0;
            staging <= 32'd0;
        end else begin
            state   <= stateNext;
            idx     <= idxNext;
            localOk <= localOkNext;
            bcastOk <= bcastOkNext;
            typeOk  <= typeOkNext;
            armed   <= armedNext;
            errSeen <= errNext;
            staging <= stageNext;
        end
    end

    // Byte-by-byte parse; armed marks a frame whose MAC+type (and opcode once seen) matched
    always_comb begin
        stateNext   = state;
        idxNext     = idx;
        localOkNext = localOk;
        bcastOkNext = bcastOk;
        typeOkNext  = typeOk;
        armedNext   = armed;
        errNext     = errSeen;
        stageNext   = staging;
        commit      = 1'b0;
        drop        = 1'b0;
        if (RxValid) begin
            errNext = errSeen | RxError;
            unique case (state)
                RX_IDLE: begin
                    localOkNext = RxData == macByte(LOCAL_MAC, 3'd0);
                    bcastOkNext = RxData == 8'hFF;
                    armedNext   = 1'b0;
                    errNext     = RxError;
                    stateNext   = RX_DST;
                end
                RX_DST: begin
                    localOkNext = localOk & (RxData == macByte(LOCAL_MAC, idx + 3'd1));
                    bcastOkNext = bcastOk & (RxData == 8'hFF);
                    if (idx == 3'd4)
                        stateNext = (localOkNext | bcastOkNext) ? RX_SRC : RX_DRAIN;
                end
                RX_SRC: begin
                    if (idx == 3'd5)
                        stateNext = RX_TYPE;
                end
                RX_TYPE: begin
                    if (idx == 3'd0)
                        typeOkNext = RxData == ETHER_TYPE[15:8];
                    else begin
                        armedNext = typeOk & (RxData == ETHER_TYPE[7:0]);
                        stateNext = armedNext ? RX_OPCODE : RX_DRAIN;
                    end
                end
                RX_OPCODE: begin
                    armedNext = armed & (RxData == OP_SLOWDOWN);
                    stateNext = armedNext ? RX_FILL : RX_DRAIN;
                end
                RX_FILL: begin
                    stageNext = {staging[23:0], RxData};
                    if (idx == 3'd3)
                        stateNext = RX_DRAIN;
                end
                default: ;
            endcase
            if (errNext && stateNext != RX_IDLE)
                stateNext = RX_DRAIN;
            if (RxLast) begin
                stateNext = RX_IDLE;
                commit = armedNext & ~errNext &
                         ((state == RX_FILL && idx == 3'd3) || state == RX_DRAIN);
                drop   = armedNext & ~commit;
            end
            idxNext = (stateNext != state) ? 3'd0 : idx + 3'd1;
        end
    end

    // Committed fill amount and saturating statistics
    always_ff @(posedge clk) begin
        if (reset) begin
            HostFiFoFillAmt <= 32'd0;
            FrameMatchCount <= 16'd0;
            FrameDropCount  <= 16'd0;
        end else begin
            if (commit)
                HostFiFoFillAmt <= stageNext;
            if (commit && FrameMatchCount != 16'hFFFF)
                FrameMatchCount <= FrameMatchCount + 16'd1;
            if (drop && FrameDropCount != 16'hFFFF)
                FrameDropCount <= FrameDropCount + 16'd1;
        end
    end

    pulse_stretch #(.HOLD_CYCLES(HOLD_CYCLES)) u_pulse (
        .clk   (clk),
        .reset (reset),
        .strobe(commit),
        .pulse (HostRequestSlowDown)
    );

endmodule

// File: tb/tb_host_slowdown_rx.sv
// tb_host_slowdown_rx: directed frame vectors plus back-to-back and mid-frame reset sequences
module tb_host_slowdown_rx;

    logic        clk;
    logic        reset;
    logic        RxValid;
    logic [7:0]  RxData;
    logic        RxLast;
    logic        RxError;
    logic        HostRequestSlowDown;
    logic [31:0] HostFiFoFillAmt;
    logic [15:0] FrameMatchCount;
    logic [15:0] FrameDropCount;

    host_slowdown_rx dut (
        .clk                (clk),
        .reset              (reset),
        .RxValid            (RxValid),
        .RxData             (RxData),
        .RxLast             (RxLast),
        .RxError            (RxError),
        .HostRequestSlowDown(HostRequestSlowDown),
        .HostFiFoFillAmt    (HostFiFoFillAmt),
        .FrameMatchCount    (FrameMatchCount),
        .FrameDropCount     (FrameDropCount)
    );

    typedef struct {
        logic [47:0] dst;
        logic [15:0] typ;
        logic [7:0]  op;
        logic [31:0] fill;
        int          pad;
        int          len;
        int          errPos;
        bit          expPulse;
        logic [31:0] expFill;
        logic [15:0] expMatch;
        logic [15:0] expDrop;
    } vec_t;

    localparam logic [47:0] MAC_OK = 48'h02_00_00_00_00_01;
    localparam logic [47:0] MAC_BC = 48'hFF_FF_FF_FF_FF_FF;

    int   applied = 0;
    int   fails = 0;
    int   reqEdges = 0;
    logic prevReq = 1'b0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (HostRequestSlowDown && !prevReq)
            reqEdges <= reqEdges + 1;
        prevReq <= HostRequestSlowDown;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        applied++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic runFrame(input vec_t v, input bit gaps, input bit measure,
                            output int width, output logic firstHigh);
        logic [7:0] b[$];
        int n;
        for (int k = 0; k < 6; k++) b.push_back(v.dst[47 - 8 * k -: 8]);
        for (int k = 0; k < 6; k++) b.push_back(8'h10 + 8'(k));
        b.push_back(v.typ[15:8]);
        b.push_back(v.typ[7:0]);
        b.push_back(v.op);
        for (int k = 0; k < 4; k++) b.push_back(v.fill[31 - 8 * k -: 8]);
        for (int k = 0; k < v.pad; k++) b.push_back(8'(k) ^ 8'h5A);
        n = (v.len > 0) ? v.len : b.size();
        for (int i = 0; i < n; i++) begin
            RxValid = 1'b1;
            RxData  = b[i];
            RxLast  = (i == n - 1);
            RxError = (i == v.errPos);
            @(posedge clk); #1;
            if (gaps && (i % 3 == 0) && i != n - 1) begin
                RxValid = 1'b0;
                RxLast  = 1'b0;
                RxError = 1'b0;
                @(posedge clk); #1;
            end
        end
        RxValid = 1'b0;
        RxLast  = 1'b0;
        RxError = 1'b0;
        firstHigh = HostRequestSlowDown;
        width = 0;
        if (measure) begin
            for (int k = 0; k < 12; k++) begin
                if (HostRequestSlowDown) width++;
                @(posedge clk); #1;
            end
        end
    endtask

    vec_t vecs[12];
    vec_t v;
    int   w;
    logic h;
    int   e0;

    initial begin
        vecs[0]  = '{MAC_OK, 16'h88B5, 8'h01, 32'h0000_1234, 40, 0, -1, 1'b1, 32'h0000_1234, 16'd1, 16'd0};
        vecs[1]  = '{48'h02_00_00_00_00_02, 16'h88B5, 8'h01, 32'h0000_9999, 40, 0, -1, 1'b0, 32'h0000_1234, 16'd1, 16'd0};
        vecs[2]  = '{MAC_OK, 16'h88B5, 8'h01, 32'h0000_8888, 10, 0, 16, 1'b0, 32'h0000_1234, 16'd1, 16'd1};
        vecs[3]  = '{MAC_OK, 16'h88B5, 8'h01, 32'hDEAD_BEEF, 0, 0, -1, 1'b1, 32'hDEAD_BEEF, 16'd2, 16'd1};
        vecs[4]  = '{MAC_BC, 16'h88B5, 8'h01, 32'h0000_0055, 5, 0, -1, 1'b1, 32'h0000_0055, 16'd3, 16'd1};
        vecs[5]  = '{MAC_OK, 16'h0800, 8'h01, 32'h0000_7777, 5, 0, -1, 1'b0, 32'h0000_0055, 16'd3, 16'd1};
        vecs[6]  = '{MAC_OK, 16'h88B5, 8'h02, 32'h0000_7777, 5, 0, -1, 1'b0, 32'h0000_0055, 16'd3, 16'd1};
        vecs[7]  = '{MAC_OK, 16'h88B5, 8'h01, 32'h0000_7777, 0, 17, -1, 1'b0, 32'h0000_0055, 16'd3, 16'd2};
        vecs[8]  = '{MAC_OK, 16'h88B5, 8'h01, 32'h0000_7777, 5, 0, 2, 1'b0, 32'h0000_0055, 16'd3, 16'd2};
        vecs[9]  = '{MAC_OK, 16'h88B5, 8'h01, 32'h0000_7777, 3, 0, 21, 1'b0, 32'h0000_0055, 16'd3, 16'd3};
        vecs[10] = '{MAC_OK, 16'h88B5, 8'h01, 32'h0000_6666, 0, 0, 18, 1'b0, 32'h0000_0055, 16'd3, 16'd4};
        vecs[11] = '{MAC_OK, 16'h88B5, 8'h01, 32'h0000_6666, 0, 14, -1, 1'b0, 32'h0000_0055, 16'd3, 16'd5};

        reset   = 1'b1;
        RxValid = 1'b0;
        RxData  = 8'h00;
        RxLast  = 1'b0;
        RxError = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset req", 32'(HostRequestSlowDown), 32'd0);
        check("reset fill", HostFiFoFillAmt, 32'd0);
        check("reset match", 32'(FrameMatchCount), 32'd0);
        check("reset drop", 32'(FrameDropCount), 32'd0);
        reset = 1'b0;
        @(posedge clk); #1;

        for (int i = 0; i < 12; i++) begin
            runFrame(vecs[i], 1'b0, 1'b1, w, h);
            check($sformatf("v%0d first", i), 32'(h), 32'(vecs[i].expPulse));
            check($sformatf("v%0d width", i), 32'(w), vecs[i].expPulse ? 32'd4 : 32'd0);
            check($sformatf("v%0d fill", i), HostFiFoFillAmt, vecs[i].expFill);
            check($sformatf("v%0d match", i), 32'(FrameMatchCount), 32'(vecs[i].expMatch));
            check($sformatf("v%0d drop", i), 32'(FrameDropCount), 32'(vecs[i].expDrop));
        end

        // Two valid frames back to back with idle gaps between beats
        e0 = reqEdges;
        v = '{MAC_OK, 16'h88B5, 8'h01, 32'h0000_0AAA, 0, 0, -1, 1'b1, 32'h0, 16'd0, 16'd0};
        runFrame(v, 1'b1, 1'b0, w, h);
        check("b2b first pulse", 32'(h), 32'd1);
        v.fill = 32'h0000_0BBB;
        runFrame(v, 1'b1, 1'b0, w, h);
        check("b2b second pulse", 32'(h), 32'd1);
        repeat (12) begin @(posedge clk); #1; end
        check("b2b edges", 32'(reqEdges - e0), 32'd2);
        check("b2b match", 32'(FrameMatchCount), 32'd5);
        check("b2b fill", HostFiFoFillAmt, 32'h0000_0BBB);

        // Reset in the middle of a frame, then a clean frame
        v = '{MAC_OK, 16'h88B5, 8'h01, 32'h0000_4444, 10, 10, -1, 1'b0, 32'h0, 16'd0, 16'd0};
        v.len = 10;
        for (int i = 0; i < 9; i++) begin
            RxValid = 1'b1;
            RxData  = (i < 6) ? v.dst[47 - 8 * i -: 8] : 8'h10;
            @(posedge clk); #1;
        end
        RxValid = 1'b0;
        reset = 1'b1;
        @(posedge clk); #1;
        check("midrst req", 32'(HostRequestSlowDown), 32'd0);
        check("midrst fill", HostFiFoFillAmt, 32'd0);
        check("midrst match", 32'(FrameMatchCount), 32'd0);
        check("midrst drop", 32'(FrameDropCount), 32'd0);
        reset = 1'b0;
        @(posedge clk); #1;
        v = '{MAC_OK, 16'h88B5, 8'h01, 32'h0000_4444, 2, 0, -1, 1'b1, 32'h0, 16'd0, 16'd0};
        runFrame(v, 1'b0, 1'b1, w, h);
        check("postrst first", 32'(h), 32'd1);
        check("postrst width", 32'(w), 32'd4);
        check("postrst fill", HostFiFoFillAmt, 32'h0000_4444);
        check("postrst match", 32'(FrameMatchCount), 32'd1);
        check("postrst drop", 32'(FrameDropCount), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", applied, fails);
        $finish;
    end

endmodule
